// File: rtl/eth_tx_arb_pkg.sv
// Shared definitions for the MAC TX frame arbiter: FSM encodings,
// the tuser bad-frame bit index and the legal requester range.
package eth_tx_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PASS  = 2'd1,
        ST_ABORT = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    localparam int TUSER_BAD   = 0;
    localparam int STALL_CNT_W = 8;
    localparam int PORTS_MIN   = 2;
    localparam int PORTS_MAX   = 4;

    function automatic bit ports_legal(input int ports);
        return (ports >= PORTS_MIN) && (ports <= PORTS_MAX);
    endfunction

    function automatic bit timeout_legal(input int timeout);
        return (timeout >= 1) && (timeout <= 255);
    endfunction

endpackage

// File: rtl/eth_mac_tx_arb_rr_pick.sv
// Combinational round-robin picker: returns the first requester strictly
// after the last winner, wrapping from N-1 back to 0, as a one-hot vector.
module rr_pick #(
    parameter int N  = 2,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  grant,
    output logic          valid
);

    logic [IW-1:0] idx;

    // Walk the requesters in rotated order starting one past the last winner
    always_comb begin
        grant = '0;
        valid = 1'b0;
        idx   = '0;
        for (int off = 1; off <= N; off++) begin
            idx = IW'((int'(last) + off) % N);
            if (!valid && req[idx]) begin
                grant[idx] = 1'b1;
                valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/eth_mac_tx_arb.sv
// Frame-granular round-robin arbiter in front of the 1G MAC TX stream.
// Holds the grant for a whole frame; a stall watchdog terminates a frame
// whose source goes quiet mid-frame with a bad-frame beat and then
// swallows the remainder of that source frame.
module eth_mac_tx_arb
    import eth_tx_arb_pkg::*;
#(
    parameter int PORTS         = 2,
    parameter int DATA_WIDTH    = 8,
    parameter int USER_WIDTH    = 1,
    parameter int STALL_TIMEOUT = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [PORTS*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [PORTS-1:0]            s_axis_tvalid,
    output logic [PORTS-1:0]            s_axis_tready,
    input  logic [PORTS-1:0]            s_axis_tlast,
    input  logic [PORTS*USER_WIDTH-1:0] s_axis_tuser,
    output logic [DATA_WIDTH-1:0]       m_axis_tdata,
    output logic                        m_axis_tvalid,
    input  logic                        m_axis_tready,
    output logic                        m_axis_tlast,
    output logic [USER_WIDTH-1:0]       m_axis_tuser,
    output logic [PORTS-1:0]            grant,
    output logic [PORTS-1:0]            frame_done,
    output logic [PORTS-1:0]            frame_abort
);

    localparam int IDX_W = $clog2(PORTS);
    localparam logic [STALL_CNT_W-1:0] STALL_LAST = STALL_CNT_W'(STALL_TIMEOUT - 1);

    if (!ports_legal(PORTS)) begin : g_bad_ports
        $error("eth_mac_tx_arb: PORTS must be in 2..4");
    end
    if (!timeout_legal(STALL_TIMEOUT)) begin : g_bad_timeout
        $error("eth_mac_tx_arb: STALL_TIMEOUT must be in 1..255");
    end

    arb_state_t               state;
    logic [IDX_W-1:0]         grant_idx;
    logic [IDX_W-1:0]         last_grant;
    logic [IDX_W-1:0]         pick_idx;
    logic [PORTS-1:0]         pick_grant;
    logic                     pick_valid;
    logic [STALL_CNT_W-1:0]   stall_cnt;
    logic                     out_free;
    logic                     sel_valid;
    logic                     sel_last;
    logic [DATA_WIDTH-1:0]    sel_data;
    logic [USER_WIDTH-1:0]    sel_user;
    logic                     accept;

    // The output register can take a beat when empty or being drained this cycle
    assign out_free  = !m_axis_tvalid || m_axis_tready;
    assign sel_valid = s_axis_tvalid[grant_idx];
    assign sel_last  = s_axis_tlast[grant_idx];
    assign sel_data  = s_axis_tdata[grant_idx*DATA_WIDTH +: DATA_WIDTH];
    assign sel_user  = s_axis_tuser[grant_idx*USER_WIDTH +: USER_WIDTH];
    assign accept    = sel_valid && s_axis_tready[grant_idx];

    rr_pick #(
        .N  (PORTS),
        .IW (IDX_W)
    ) u_rr_pick (
        .req   (s_axis_tvalid),
        .last  (last_grant),
        .grant (pick_grant),
        .valid (pick_valid)
    );

    // Convert the picker's one-hot winner into a port index for muxing
    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < PORTS; i++) begin
            if (pick_grant[i]) begin
                pick_idx = IDX_W'(i);
            end
        end
    end

    // Only the owner sees ready: gated by output space while passing, forced while draining
    always_comb begin
        s_axis_tready = '0;
        case (state)
            ST_PASS:  s_axis_tready[grant_idx] = out_free;
            ST_DRAIN: s_axis_tready[grant_idx] = 1'b1;
            default:  s_axis_tready = '0;
        endcase
    end

    // Arbitration FSM, stall watchdog and the registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            grant         <= '0;
            grant_idx     <= '0;
            last_grant    <= IDX_W'(PORTS - 1);
            stall_cnt     <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
            frame_done    <= '0;
            frame_abort   <= '0;
        end else begin
            frame_done  <= '0;
            frame_abort <= '0;
            if (m_axis_tready) begin
                m_axis_tvalid <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (pick_valid) begin
                        grant     <= pick_grant;
                        grant_idx <= pick_idx;
                        stall_cnt <= '0;
                        state     <= ST_PASS;
                    end
                end
                ST_PASS: begin
                    if (accept) begin
                        m_axis_tdata  <= sel_data;
                        m_axis_tlast  <= sel_last;
                        m_axis_tuser  <= sel_user;
                        m_axis_tvalid <= 1'b1;
                        stall_cnt     <= '0;
                        if (sel_last) begin
                            frame_done <= grant;
                            last_grant <= grant_idx;
                            grant      <= '0;
                            state      <= ST_IDLE;
                        end
                    end else if (out_free) begin
                        if (stall_cnt == STALL_LAST) begin
                            state <= ST_ABORT;
                        end else begin
                            stall_cnt <= stall_cnt + 1'b1;
                        end
                    end
                end
                ST_ABORT: begin
                    if (out_free) begin
                        m_axis_tdata            <= '0;
                        m_axis_tlast            <= 1'b1;
                        m_axis_tuser            <= '0;
                        m_axis_tuser[TUSER_BAD] <= 1'b1;
                        m_axis_tvalid           <= 1'b1;
                        frame_abort             <= grant;
                        state                   <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (accept && sel_last) begin
                        last_grant <= grant_idx;
                        grant      <= '0;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_mac_tx_arb.sv
// Directed bench for eth_mac_tx_arb: four ports, watchdog timeout of 4.
module tb_eth_mac_tx_arb;

    localparam int PORTS = 4;
    localparam int DW    = 8;
    localparam int UW    = 1;
    localparam int TO    = 4;

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic       user;
    } beat_t;

    typedef struct packed {
        logic [7:0]  data;
        logic        last;
        logic        user;
        logic [31:0] cyc;
    } out_t;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [PORTS*DW-1:0]   s_axis_tdata;
    logic [PORTS-1:0]      s_axis_tvalid;
    logic [PORTS-1:0]      s_axis_tready;
    logic [PORTS-1:0]      s_axis_tlast;
    logic [PORTS*UW-1:0]   s_axis_tuser;
    logic [DW-1:0]         m_axis_tdata;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic                  m_axis_tlast;
    logic [UW-1:0]         m_axis_tuser;
    logic [PORTS-1:0]      grant;
    logic [PORTS-1:0]      frame_done;
    logic [PORTS-1:0]      frame_abort;

    beat_t            src_q [PORTS][$];
    out_t             out_q [$];
    int               grant_log [$];
    int               done_cnt [PORTS];
    int               abort_cnt [PORTS];
    int               cyc = 0;
    logic [PORTS-1:0] prev_grant = '0;
    logic             m_ready_toggle = 1'b0;
    int               check_count = 0;
    int               pass_count = 0;

    eth_mac_tx_arb #(
        .PORTS         (PORTS),
        .DATA_WIDTH    (DW),
        .USER_WIDTH    (UW),
        .STALL_TIMEOUT (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_tuser  (s_axis_tuser),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_tuser  (m_axis_tuser),
        .grant         (grant),
        .frame_done    (frame_done),
        .frame_abort   (frame_abort)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record delivered beats, completion pulses and each new grant
    always @(negedge clk) begin
        if (!rst) begin
            if (m_axis_tvalid && m_axis_tready) begin
                out_q.push_back(out_t'({m_axis_tdata, m_axis_tlast, m_axis_tuser[0], 32'(cyc)}));
            end
            for (int p = 0; p < PORTS; p++) begin
                if (frame_done[p])  done_cnt[p]++;
                if (frame_abort[p]) abort_cnt[p]++;
                if (grant[p] && prev_grant == '0) grant_log.push_back(p);
            end
        end
        prev_grant = grant;
    end

    // Source and sink driver: pops handshaked beats and presents the next ones
    initial begin : driver
        logic [PORTS-1:0] fire;
        s_axis_tvalid = '0;
        s_axis_tdata  = '0;
        s_axis_tlast  = '0;
        s_axis_tuser  = '0;
        m_axis_tready = 1'b1;
        forever begin
            @(negedge clk);
            fire = s_axis_tvalid & s_axis_tready;
            @(posedge clk);
            #1;
            for (int p = 0; p < PORTS; p++) begin
                if (fire[p] && src_q[p].size() > 0) void'(src_q[p].pop_front());
                if (src_q[p].size() > 0) begin
                    s_axis_tvalid[p]        = 1'b1;
                    s_axis_tdata[p*DW +: DW] = src_q[p][0].data;
                    s_axis_tlast[p]         = src_q[p][0].last;
                    s_axis_tuser[p]         = src_q[p][0].user;
                end else begin
                    s_axis_tvalid[p]        = 1'b0;
                    s_axis_tdata[p*DW +: DW] = '0;
                    s_axis_tlast[p]         = 1'b0;
                    s_axis_tuser[p]         = 1'b0;
                end
            end
            m_axis_tready = m_ready_toggle ? !m_axis_tready : 1'b1;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clearLogs();
        out_q.delete();
        grant_log.delete();
        for (int p = 0; p < PORTS; p++) begin
            done_cnt[p]  = 0;
            abort_cnt[p] = 0;
        end
    endtask

    task automatic applyReset();
        rst = 1'b1;
        m_ready_toggle = 1'b0;
        for (int p = 0; p < PORTS; p++) src_q[p].delete();
        tick(3);
        rst = 1'b0;
        clearLogs();
    endtask

    task automatic applyStimulus(input int port, input int n, input int base, input bit with_last);
        for (int i = 0; i < n; i++) begin
            src_q[port].push_back(beat_t'({8'(base + i), (with_last && i == n - 1), 1'b0}));
        end
    endtask

    task automatic waitCount(input string tag, input int port, input int n, input bit abort_kind, input int budget);
        int k;
        int cnt;
        k   = 0;
        cnt = abort_kind ? abort_cnt[port] : done_cnt[port];
        while (cnt < n && k < budget) begin
            tick();
            k++;
            cnt = abort_kind ? abort_cnt[port] : done_cnt[port];
        end
        checkOutput(tag, 32'(cnt >= n), 32'd1);
        tick(3);
    endtask

    function automatic out_t outAt(input int i);
        if (i < out_q.size()) return out_q[i];
        return '1;
    endfunction

    task automatic checkRun(input string tag, input int first, input int n, input int base, input bit last_at_end);
        int   bad;
        out_t o;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            o = outAt(first + i);
            if (o.data !== 8'(base + i) || o.last !== (last_at_end && i == n - 1) || o.user !== 1'b0) bad++;
        end
        checkOutput(tag, 32'(bad), 32'd0);
    endtask

    function automatic logic [31:0] logCode();
        logic [31:0] code;
        code = '0;
        for (int i = 0; i < grant_log.size() && i < 8; i++) begin
            code = code | (32'(grant_log[i]) << (4 * i));
        end
        return code;
    endfunction

    initial begin : timeout_guard
        #1000000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : main
        out_t o;
        rst = 1'b1;
        tick(3);
        checkOutput("reset_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("reset_m_data",   32'({m_axis_tdata, m_axis_tlast, m_axis_tuser}), 32'd0);
        checkOutput("reset_grant",    32'(grant), 32'd0);
        checkOutput("reset_s_tready", 32'(s_axis_tready), 32'd0);
        checkOutput("reset_pulses",   32'({frame_done, frame_abort}), 32'd0);
        rst = 1'b0;
        clearLogs();

        $display("[TB] single source, 60 bytes on port 0");
        applyStimulus(0, 60, 0, 1'b1);
        waitCount("single_done_seen", 0, 1, 1'b0, 300);
        checkOutput("single_beats", 32'(out_q.size()), 32'd60);
        checkRun("single_data", 0, 60, 0, 1'b1);
        checkOutput("single_done_cnt", 32'(done_cnt[0]), 32'd1);
        checkOutput("single_grant_idle", 32'(grant), 32'd0);

        $display("[TB] fairness, ports 0 and 1 with 3 frames each");
        applyReset();
        for (int f = 0; f < 3; f++) begin
            applyStimulus(0, 4, f * 8, 1'b1);
            applyStimulus(1, 4, 64 + f * 8, 1'b1);
        end
        waitCount("fair_done_seen", 1, 3, 1'b0, 300);
        checkOutput("fair_grants", 32'(grant_log.size()), 32'd6);
        checkOutput("fair_order", logCode(), 32'h0010_1010);
        checkOutput("fair_beats", 32'(out_q.size()), 32'd24);
        for (int f = 0; f < 3; f++) begin
            checkRun($sformatf("fair_p0_f%0d", f), 8 * f,     4, f * 8,      1'b1);
            checkRun($sformatf("fair_p1_f%0d", f), 8 * f + 4, 4, 64 + f * 8, 1'b1);
        end

        $display("[TB] backpressure, port 1 with toggling ready");
        applyReset();
        m_ready_toggle = 1'b1;
        applyStimulus(1, 10, 96, 1'b1);
        waitCount("bp_done_seen", 1, 1, 1'b0, 200);
        tick(2);
        checkOutput("bp_beats", 32'(out_q.size()), 32'd10);
        checkRun("bp_data", 0, 10, 96, 1'b1);
        checkOutput("bp_order", logCode(), 32'h0000_0001);
        m_ready_toggle = 1'b0;

        $display("[TB] watchdog, port 0 stalls after 5 bytes");
        applyReset();
        applyStimulus(0, 5, 0, 1'b0);
        applyStimulus(1, 3, 64, 1'b1);
        waitCount("wd_abort_seen", 0, 1, 1'b1, 100);
        applyStimulus(0, 20, 5, 1'b1);
        waitCount("wd_p1_done_seen", 1, 1, 1'b0, 200);
        checkOutput("wd_beats", 32'(out_q.size()), 32'd9);
        checkRun("wd_head", 0, 5, 0, 1'b0);
        o = outAt(5);
        checkOutput("wd_abort_beat", 32'({o.data, o.last, o.user}), 32'({8'h00, 1'b1, 1'b1}));
        checkOutput("wd_abort_delay", outAt(5).cyc - outAt(4).cyc, 32'(TO + 1));
        checkRun("wd_p1_frame", 6, 3, 64, 1'b1);
        checkOutput("wd_done_p0", 32'(done_cnt[0]), 32'd0);
        checkOutput("wd_abort_p0", 32'(abort_cnt[0]), 32'd1);
        checkOutput("wd_order", logCode(), 32'h0000_0010);

        $display("[TB] reset in the middle of a port 2 frame");
        applyReset();
        applyStimulus(2, 8, 128, 1'b1);
        begin
            int k;
            k = 0;
            while (out_q.size() < 3 && k < 50) begin
                tick();
                k++;
            end
            checkOutput("rst_mid_reached", 32'(out_q.size() >= 3), 32'd1);
        end
        rst = 1'b1;
        for (int p = 0; p < PORTS; p++) src_q[p].delete();
        tick();
        checkOutput("rst_mid_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        checkOutput("rst_mid_outputs",
                    32'({m_axis_tlast, m_axis_tuser, m_axis_tdata, grant, s_axis_tready, frame_done, frame_abort}),
                    32'd0);
        rst = 1'b0;
        clearLogs();
        applyStimulus(1, 2, 64, 1'b1);
        applyStimulus(0, 2, 0, 1'b1);
        waitCount("rst_after_done_seen", 1, 1, 1'b0, 100);
        checkOutput("rst_after_order", logCode(), 32'h0000_0010);
        checkRun("rst_after_p0", 0, 2, 0, 1'b1);

        $display("[TB] wrap-around, ports 3 and 0");
        applyReset();
        applyStimulus(3, 2, 192, 1'b1);
        applyStimulus(3, 2, 200, 1'b1);
        applyStimulus(0, 2, 0, 1'b1);
        applyStimulus(0, 2, 8, 1'b1);
        waitCount("wrap_done_seen", 3, 2, 1'b0, 200);
        checkOutput("wrap_grants", 32'(grant_log.size()), 32'd4);
        checkOutput("wrap_order", logCode(), 32'h0000_3030);
        checkRun("wrap_p3_f1", 6, 2, 200, 1'b1);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/eth_mac_tx_arb.md
# eth_mac_tx_arb

Frame-granular round-robin arbiter that shares the single TX AXI-stream input of the 1G MAC between up to four frame sources, e.g. the ROS2 packet builder and an ARP/ICMP responder. It sits directly in front of the MAC's `tx_axis_*` port and holds the grant for a whole frame. A per-frame stall watchdog prevents a stalled source from starving the MAC into underflow. When the watchdog fires, the block terminates the outgoing frame as bad and discards the rest of the offending source frame.

## Interface
- `PORTS`, 2: number of requesters; legal range 2..4.
- `DATA_WIDTH`, 8: tdata width; matches the MAC GMII byte path.
- `USER_WIDTH`, 1: tuser width; bit 0 is the bad-frame flag.
- `STALL_TIMEOUT`, 16: consecutive mid-frame idle cycles before abort; legal range 1..255.

Ports:
- `clk`  in  1: single clock; the MAC `tx_clk`. One clock only.
- `rst`  in  1: reset, synchronous and active-high.
- `s_axis_tdata`  in  PORTS*DATA_WIDTH: per-port data, port i in slice i.
- `s_axis_tvalid`  in  PORTS: per-port valid.
- `s_axis_tready`  out  PORTS: per-port ready.
- `s_axis_tlast`  in  PORTS: per-port end of frame.
- `s_axis_tuser`  in  PORTS*USER_WIDTH: per-port user.
- `m_axis_tdata`  out  DATA_WIDTH: to the MAC `tx_axis_tdata`.
- `m_axis_tvalid`  out  1: to the MAC.
- `m_axis_tready`  in  1: from the MAC.
- `m_axis_tlast`  out  1: to the MAC.
- `m_axis_tuser`  out  USER_WIDTH: to the MAC.
- `grant`  out  PORTS: one-hot current owner; 0 when idle.
- `frame_done`  out  PORTS: one-cycle pulse when port i's frame completes normally.
- `frame_abort`  out  PORTS: one-cycle pulse when port i's frame is aborted by the watchdog.

## Operation
- **FSM states:** IDLE, PASS, ABORT, DRAIN.
- **IDLE:**
  - The request vector is `s_axis_tvalid`.
  - Select the first requesting port strictly after `last_grant`, in round-robin order, wrapping from PORTS-1 to 0.
  - Load `grant` and go to PASS.
  - No input is accepted in the IDLE cycle.
  - `last_grant` resets to PORTS-1, so port 0 wins first.
- **PASS:**
  - `s_axis_tready[g] = !m_axis_tvalid || m_axis_tready`; all other readies are 0.
  - An accepted beat is copied into the output register: data, last, user.
  - If the accepted beat has tlast, pulse `frame_done[g]` in that same cycle and go to IDLE. Set `last_grant = g` and clear `grant`.
- **Watchdog (in PASS):**
  - `stall_cnt` (8 bit) increments on every cycle with `!s_axis_tvalid[g]` while the output register can accept a beat.
  - It clears on any accepted beat.
  - When `stall_cnt == STALL_TIMEOUT-1` and the source is still idle, go to ABORT.
  - The counter is never used outside PASS and is cleared on entry to PASS.
- **ABORT:**
  - When the output register is free, load one beat: data 0, tlast=1, tuser[0]=1.
  - Pulse `frame_abort[g]` and go to DRAIN.
  - The MAC records this frame as bad, so no underflow occurs.
- **DRAIN:**
  - `s_axis_tready[g] = 1`; all beats from port g are discarded and nothing is output.
  - On an accepted tlast, go to IDLE and set `last_grant = g`.
- **Output register:**
  - `m_axis_tvalid` clears when `m_axis_tready` is high and no new beat is loaded.
  - Back-to-back beats flow at 1 beat/cycle.
- **Simultaneous events:**
  - The last beat of frame A can still be held in the output register while IDLE arbitrates B. B's first beat waits for register space under the ready rule.
  - A port that deasserts tvalid before grant simply loses arbitration; valid is not required to be sticky.
- **tuser passthrough:** an accepted bad-frame tuser is passed through unchanged.
- **Reset mid-frame:**
  - All state returns to IDLE; `m_axis_tvalid` drops in the next cycle.
  - The partial frame already in the MAC is left to the MAC's own underflow handling.

## Timing
- **Reset values:** `m_axis_tvalid`=0, `m_axis_tdata`/`tlast`/`tuser`=0, `s_axis_tready`=0, `grant`=0, `frame_done`=0, `frame_abort`=0, FSM=IDLE.
- **Latency:** 1 cycle from input accept to `m_axis_tvalid`.
- **Arbitration overhead:** 1 idle cycle per frame (the IDLE state).
- **Frame-to-frame gap:**
  - Between two frames on the output stream the gap is at least 1 cycle.
  - The MAC inter-frame gap dominates anyway.
- **Abort timing:** the termination beat is presented STALL_TIMEOUT+1 cycles after the last accepted beat, provided `m_axis_tready` is high.
- **Combinational path:** `s_axis_tready` depends combinationally on `m_axis_tready`. No other input-to-output combinational path exists.

## Structure
- **Shared package:** add an `eth_tx_arb_pkg` header, included like `ros2_ether_config.vh`. It holds the state encodings, the TUSER_BAD bit index (0), and the PORTS range check macro.
- **Sub-module:** one sub-module, `rr_pick`. It is a combinational round-robin priority picker (request vector, last grant → one-hot grant plus valid). It is reusable by future RX demux/arbiters.

## Test plan
- **Single source:** port 0 sends a 60-byte frame with the MAC always ready → 60 output beats in order. tlast is set on beat 60, `frame_done[0]` pulses once, and `grant` returns to 0.
- **Fairness:** ports 0 and 1 request continuously with 3 frames each → output order 0,1,0,1,0,1, with no beats interleaved within a frame.
- **Backpressure:** port 1 streams a 10-byte frame while `m_axis_tready` toggles every cycle → all 10 bytes are delivered unchanged, with no duplicates or drops.
- **Watchdog:** STALL_TIMEOUT=4, and port 0 drops tvalid after byte 5 → after 5 idle cycles one beat (0x00, tlast=1, tuser=1) is output and `frame_abort[0]` pulses. The remaining 20 bytes are discarded, then port 1 is served.
- **Reset mid-frame:** assert `rst` during beat 3 of a frame → all outputs are 0 the cycle after reset. After reset, port 0 wins the first arbitration.
- **Wrap-around:** PORTS=4 with only ports 3 and 0 requesting, starting `last_grant`=3 → grant order 0,3,0,3.
